inv_shift_rows_serial: RTL and testbench

Byte-serial AES InvShiftRows stage for the decryption datapath. Accepts a 16-byte state as a valid/ready byte stream, buffers it in one of two ping-pong banks, and emits the row-shifted state as a byte stream. Sustains 1 byte/cycle. Parameter `INVERSE=0` selects forward ShiftRows for loopback checks against the encryption path.

---
 rtl/inv_shift_rows_serial.sv | 144 ++++++++++++++
 tb/tb_inv_shift_rows_serial.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_shift_rows_serial.sv
// Byte-serial AES (Inv)ShiftRows: each 16-byte block lands in one of two ping-pong banks and is re-read in row-shifted order.
// Latency: output byte 0 is valid the cycle after input byte 15 is accepted; 1 byte/cycle sustained in and out.
// Backpressure: in_ready drops while the write bank still holds an undrained block; in_ready comes only from registered flags.
module inv_shift_rows_serial #(
  // 1: InvShiftRows (row r rotated right by r); 0: forward ShiftRows (row r rotated left by r)
  parameter bit INVERSE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       frame_err
);

  // Block storage: two banks of 16 bytes, indexed by stream position k = r + 4c
  logic [7:0] r_mem [2][16];

  // Per-bank occupancy: 1 from the cycle after the 16th write until the 16th read
  logic [1:0] r_full;

  // Write side pointer
  logic       r_wr_bank;
  logic [3:0] r_wr_cnt;

  // Read side pointer
  logic       r_rd_bank;
  logic [3:0] r_rd_cnt;

  // Sticky framing error
  logic       r_frame_err;

  // Handshake and block-boundary strobes
  logic       w_in_fire;
  logic       w_out_fire;
  logic       w_wr_done;
  logic       w_rd_done;
  logic       w_last_slot;

  // Read address translation: output position (row, col) -> source column
  logic [1:0] w_rd_row;
  logic [1:0] w_rd_col;
  logic [1:0] w_src_col;
  logic [3:0] w_src;

  // The write bank is free exactly when its full flag is clear; the read
  // side only ever clears a flag at a clock edge, so a bank that finishes
  // draining becomes writable one cycle later, never in the same cycle.
  assign in_ready   = !r_full[r_wr_bank];
  assign out_valid  = r_full[r_rd_bank];

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  assign w_last_slot = (r_wr_cnt == 4'd15);
  assign w_wr_done   = w_in_fire && w_last_slot;
  assign w_rd_done   = w_out_fire && (r_rd_cnt == 4'd15);

  assign w_rd_row = r_rd_cnt[1:0];
  assign w_rd_col = r_rd_cnt[3:2];

  // Source column for the byte at (row, col): all arithmetic wraps mod 4
  always_comb begin
    w_src_col = w_rd_col;
    if (INVERSE) begin
      w_src_col = w_rd_col - w_rd_row;
    end else begin
      w_src_col = w_rd_col + w_rd_row;
    end
  end

  // Row index is unchanged by the shift; only the column moves
  assign w_src = {w_src_col, w_rd_row};

  // Output byte and frame marker are decoded purely from registered state
  assign out_data  = r_mem[r_rd_bank][w_src];
  assign out_last  = out_valid && (r_rd_cnt == 4'd15);
  assign frame_err = r_frame_err;

  // Bank write port: contents need no reset, full flags gate their use
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_mem[r_wr_bank][r_wr_cnt] <= in_data;
    end
  end

  // Write pointer: count bytes, hop to the other bank after byte 15
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt  <= 4'd0;
      r_wr_bank <= 1'b0;
    end else if (w_in_fire) begin
      r_wr_cnt <= r_wr_cnt + 4'd1;
      if (w_last_slot) begin
        r_wr_bank <= ~r_wr_bank;
      end
    end
  end

  // Read pointer: count bytes out, hop to the other bank after byte 15
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_cnt  <= 4'd0;
      r_rd_bank <= 1'b0;
    end else if (w_out_fire) begin
      r_rd_cnt <= r_rd_cnt + 4'd1;
      if (r_rd_cnt == 4'd15) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Full flags: fill-complete and drain-complete always target different
  // banks (a bank is writable only when empty and readable only when full),
  // so both updates can land in the same cycle without conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 2'b00;
    end else begin
      if (w_wr_done) begin
        r_full[r_wr_bank] <= 1'b1;
      end
      if (w_rd_done) begin
        r_full[r_rd_bank] <= 1'b0;
      end
    end
  end

  // Framing check: in_last must coincide with the 16th byte; block
  // boundaries themselves are always taken from the write counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else if (w_in_fire && (in_last != w_last_slot)) begin
      r_frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// Bench for inv_shift_rows_serial: a matrix-level ShiftRows model and per-cycle compare,
// with literal vectors for the INVERSE=1 / INVERSE=0 orderings and a forward->inverse chain.
module tb_inv_shift_rows_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (InvShiftRows)
  logic       rst;
  logic       in_valid, in_ready, in_last;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_last;
  logic [7:0] out_data;
  logic       frame_err;

  // Forward -> inverse chain
  logic       c_in_valid, c_in_ready, c_in_last;
  logic [7:0] c_in_data;
  logic       l_valid, l_ready, l_last;
  logic [7:0] l_data;
  logic       c_out_valid, c_out_ready, c_out_last;
  logic [7:0] c_out_data;
  logic       f_err_a, f_err_b;

  inv_shift_rows_serial #(.INVERSE(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frame_err(frame_err)
  );

  inv_shift_rows_serial #(.INVERSE(1'b0)) u_fwd (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_last(c_in_last),
    .out_valid(l_valid), .out_ready(l_ready), .out_data(l_data), .out_last(l_last),
    .frame_err(f_err_a)
  );

  inv_shift_rows_serial #(.INVERSE(1'b1)) u_bwd (
    .clk(clk), .rst(rst),
    .in_valid(l_valid), .in_ready(l_ready), .in_data(l_data), .in_last(l_last),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_last(c_out_last),
    .frame_err(f_err_b)
  );

  // Hand-computed reference orderings for input 00..0f
  logic [7:0] lit_inv [16] = '{8'h00, 8'h0d, 8'h0a, 8'h07, 8'h04, 8'h01, 8'h0e, 8'h0b,
                               8'h08, 8'h05, 8'h02, 8'h0f, 8'h0c, 8'h09, 8'h06, 8'h03};
  logic [7:0] lit_fwd [16] = '{8'h00, 8'h05, 8'h0a, 8'h0f, 8'h04, 8'h09, 8'h0e, 8'h03,
                               8'h08, 8'h0d, 8'h02, 8'h07, 8'h0c, 8'h01, 8'h06, 8'h0b};

  int n_cmp;
  int n_err;

  // Model state
  logic [8:0] exp_q [$];   // {last, data} of bytes the DUT still owes
  logic [8:0] obs_q [$];   // {last, data} of bytes the DUT delivered
  logic [7:0] in_blk [16];
  int         in_pos;
  bit         m_ferr;
  int         n_acc;
  int         cyc;
  int         in_cyc [$];
  int         out_cyc [$];
  logic [8:0] link_q [$];
  logic [8:0] fin_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Treat the block as a 4x4 matrix s[r][c] = blk[r + 4c]; InvShiftRows
  // rotates row r right by r, so output column c takes input column c - r.
  task automatic push_block();
    int r, c, sc;
    for (int k = 0; k < 16; k++) begin
      r  = k % 4;
      c  = k / 4;
      sc = (c - r + 4) % 4;
      exp_q.push_back({(k == 15), in_blk[r + 4 * sc]});
    end
  endtask

  // Per-cycle compare, sampled on the falling edge
  task automatic cmp_cycle();
    cyc++;
    if (rst) begin
      exp_q.delete();
      in_pos = 0;
      m_ferr = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_in_ready", in_ready, 1);
    end else begin
      // Blocks held = ceil(owed bytes / 16); input stalls only with two held
      chk("in_ready", in_ready, (exp_q.size() <= 16) ? 1 : 0);
      chk("out_valid", out_valid, (exp_q.size() != 0) ? 1 : 0);
      chk("frame_err", frame_err, m_ferr);
      if (exp_q.size() != 0) begin
        chk("out_data", out_data, exp_q[0][7:0]);
        chk("out_last", out_last, exp_q[0][8]);
        if (out_ready) begin
          obs_q.push_back({out_last, out_data});
          out_cyc.push_back(cyc);
          void'(exp_q.pop_front());
        end
      end else begin
        chk("out_last_idle", out_last, 0);
      end
      if (in_valid && in_ready) begin
        n_acc++;
        in_cyc.push_back(cyc);
        if (in_last != (in_pos == 15)) m_ferr = 1'b1;
        in_blk[in_pos] = in_data;
        if (in_pos == 15) push_block();
        in_pos = (in_pos + 1) % 16;
      end
    end
  endtask

  task automatic chain_mon();
    if (!rst) begin
      if (l_valid && l_ready) link_q.push_back({l_last, l_data});
      if (c_out_valid && c_out_ready) fin_q.push_back({c_out_last, c_out_data});
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int  guard;
    bit  acc;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      guard++;
    end while (!acc && guard < 500);
    chk("send_accept", acc, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic c_send_byte(input logic [7:0] d, input logic l);
    int  guard;
    bit  acc;
    guard = 0;
    c_in_valid = 1'b1;
    c_in_data  = d;
    c_in_last  = l;
    do begin
      @(negedge clk);
      acc = c_in_ready;
      tick();
      guard++;
    end while (!acc && guard < 100);
    chk("chain_send_accept", acc, 1);
    c_in_valid = 1'b0;
    c_in_last  = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 400) begin
      tick();
      g++;
    end
    chk("drain_complete", exp_q.size(), 0);
    tick();
  endtask

  task automatic chk_lit_block(input string nm, input int base, input logic [7:0] exp [16]);
    chk({nm, "_count"}, obs_q.size() - base, 16);
    for (int i = 0; i < 16 && base + i < obs_q.size(); i++) begin
      chk({nm, "_data"}, obs_q[base + i][7:0], exp[i]);
      chk({nm, "_last"}, obs_q[base + i][8], (i == 15) ? 1 : 0);
    end
  endtask

  // Last-resort bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded its time bound");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  base, acc0, ib, ob;
    bit  snd_done, rnd_on;

    n_cmp = 0; n_err = 0;
    in_pos = 0; m_ferr = 1'b0; n_acc = 0; cyc = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_data = 8'h00; c_in_last = 1'b0; c_out_ready = 1'b1;
    snd_done = 1'b0; rnd_on = 1'b0;

    fork
      forever begin @(negedge clk); cmp_cycle(); end
      forever begin @(negedge clk); chain_mon(); end
    join_none

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    tick();

    // Single block 00..0f, ready always high, latency and exact order
    base = obs_q.size();
    for (int i = 0; i < 16; i++) send_byte(8'(i), (i == 15));
    @(negedge clk);
    chk("s1_latency_out_valid", out_valid, 1);
    chk("s1_first_byte", out_data, 8'h00);
    tick();
    drain();
    chk_lit_block("s1", base, lit_inv);

    // Forward instance alone gives ShiftRows order; chained back gives identity
    for (int i = 0; i < 16; i++) c_send_byte(8'(i), (i == 15));
    repeat (40) tick();
    chk("chain_link_count", link_q.size(), 16);
    chk("chain_out_count", fin_q.size(), 16);
    for (int i = 0; i < 16 && i < link_q.size(); i++) chk("chain_fwd_data", link_q[i][7:0], lit_fwd[i]);
    for (int i = 0; i < 16 && i < fin_q.size(); i++) chk("chain_roundtrip", fin_q[i][7:0], 8'(i));
    if (fin_q.size() >= 16) chk("chain_out_last", fin_q[15][8], 1);
    chk("chain_frame_err", {f_err_a, f_err_b}, 2'b00);

    // Backpressure: 48 bytes offered, only 32 fit
    out_ready = 1'b0;
    acc0 = n_acc;
    base = obs_q.size();
    snd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 48; i++) send_byte(8'(8'h40 + i), ((i % 16) == 15));
        snd_done = 1'b1;
      end
    join_none
    repeat (60) tick();
    @(negedge clk);
    chk("bp_accepted", n_acc - acc0, 32);
    chk("bp_in_ready_low", in_ready, 0);
    tick();
    out_ready = 1'b1;
    for (int g = 0; g < 300 && !snd_done; g++) tick();
    chk("bp_sender_done", snd_done, 1);
    drain();
    chk("bp_out_count", obs_q.size() - base, 48);

    // Random blocks with random in_valid gaps and out_ready toggling
    base = obs_q.size();
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          tick();
          if (rnd_on) out_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 16; i++) begin
        while ($urandom_range(0, 1) == 1) tick();
        send_byte(8'($urandom_range(0, 255)), (i == 15));
      end
    end
    rnd_on = 1'b0;
    tick();
    tick();
    out_ready = 1'b1;
    drain();
    chk("rnd_out_count", obs_q.size() - base, 96);

    // Full rate: four back-to-back blocks, no bubbles either side
    ib = in_cyc.size();
    ob = out_cyc.size();
    for (int i = 0; i < 64; i++) send_byte(8'($urandom_range(0, 255)), ((i % 16) == 15));
    drain();
    if (in_cyc.size() >= ib + 64 && out_cyc.size() >= ob + 64) begin
      chk("tp_in_span", in_cyc[ib + 63] - in_cyc[ib], 63);
      chk("tp_out_span", out_cyc[ob + 63] - out_cyc[ob], 63);
      chk("tp_first_latency", out_cyc[ob] - in_cyc[ib + 15], 1);
    end else begin
      chk("tp_transfer_count", (in_cyc.size() - ib) + (out_cyc.size() - ob), 128);
    end

    // Framing: in_last on byte 7 only
    base = obs_q.size();
    for (int i = 0; i < 16; i++) begin
      send_byte(8'($urandom_range(0, 255)), (i == 7));
      if (i == 7) begin
        @(negedge clk);
        chk("frm_err_next_cycle", frame_err, 1);
        tick();
      end
    end
    drain();
    chk("frm_err_sticky", frame_err, 1);
    chk("frm_out_count", obs_q.size() - base, 16);
    if (obs_q.size() >= base + 16) chk("frm_out_last_16th", obs_q[base + 15][8], 1);

    // Reset with block 0 draining and block 1 part-written
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)), (i == 15));
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_frame_err", frame_err, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    base = obs_q.size();
    for (int i = 0; i < 16; i++) send_byte(8'(i), (i == 15));
    drain();
    chk_lit_block("post_rst", base, lit_inv);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
